// File: rtl/prbs_err_monitor_pkg.sv
// Shared types and helpers for the PRBS error monitor: lane state encoding,
// saturating add and counter-width helpers.
package prbs_mon_pkg;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } prbs_state_e;

  // Width needed to hold the values 0..n, never less than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Add inc to val and clamp at maxv; operands are zero-extended by the caller.
  function automatic logic [63:0] sat_add(input logic [63:0] val,
                                          input logic [63:0] inc,
                                          input logic [63:0] maxv);
    logic [64:0] sum;
    sum = {1'b0, val} + {1'b0, inc};
    return (sum > {1'b0, maxv}) ? maxv : sum[63:0];
  endfunction

endpackage

// File: rtl/prbs_err_monitor_if.sv
// Bus between the PRBS checkers / VIO and the monitor back-end.
// The err_total port exists only when PRBS_ERR_TOTAL_EN is defined.
interface prbs_err_monitor_if #(
  parameter int NCH   = 8,
  parameter int CNT_W = 16
);
  logic [NCH-1:0]       PRBS_error;
  logic                 inject;
  logic                 PRBS_counter_reset_user;
  logic                 inject_pulse;
  logic [NCH-1:0]       lock;
  logic [NCH*CNT_W-1:0] err_cnt;
  logic [NCH-1:0]       err_sticky;
  logic [NCH-1:0]       led_fp;
`ifdef PRBS_ERR_TOTAL_EN
  logic [CNT_W+$clog2(NCH)-1:0] err_total;

  modport master (
    output PRBS_error, inject, PRBS_counter_reset_user,
    input  inject_pulse, lock, err_cnt, err_sticky, led_fp, err_total
  );
  modport slave (
    input  PRBS_error, inject, PRBS_counter_reset_user,
    output inject_pulse, lock, err_cnt, err_sticky, led_fp, err_total
  );
`else
  modport master (
    output PRBS_error, inject, PRBS_counter_reset_user,
    input  inject_pulse, lock, err_cnt, err_sticky, led_fp
  );
  modport slave (
    input  PRBS_error, inject, PRBS_counter_reset_user,
    output inject_pulse, lock, err_cnt, err_sticky, led_fp
  );
`endif
endinterface

// File: rtl/prbs_err_monitor_chan.sv
// One PRBS lane: SEARCH/LOCKED tracking, saturating error count, sticky flag
// and LED stretch.
module prbs_err_chan
  import prbs_mon_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int LOCK_CYC = 255,
  parameter int LOSS_CYC = 4,
  parameter int LED_HOLD = 2**20-1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             err_i,
  input  logic             clr_i,
  output logic             lock_o,
  output logic             cnt_en_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sticky_o,
  output logic             led_o
);
  localparam int RUN_W  = cnt_width(LOCK_CYC);
  localparam int LOSS_W = cnt_width(LOSS_CYC);
  localparam int HOLD_W = cnt_width(LED_HOLD);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CYC - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(LED_HOLD);
  localparam logic [63:0]       CNT_MAX   = (64'd1 << CNT_W) - 64'd1;

  prbs_state_e       state_q, state_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sticky_q, sticky_d;
  logic              lock_q, led_q;
  logic              cnt_en;

  // The run that completes the lock/loss threshold switches state on that same edge.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    loss_d   = loss_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    hold_d   = hold_q;
    cnt_en   = 1'b0;
    case (state_q)
      ST_SEARCH: begin
        if (err_i) begin
          run_d = '0;
        end else if (run_q == RUN_LAST) begin
          state_d = ST_LOCKED;
          run_d   = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
      ST_LOCKED: begin
        if (err_i) begin
          cnt_en = 1'b1;
          if (loss_q == LOSS_LAST) begin
            state_d = ST_SEARCH;
            loss_d  = '0;
          end else begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end else begin
          loss_d = '0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (cnt_en) begin
      cnt_d    = CNT_W'(sat_add(64'(cnt_q), 64'd1, CNT_MAX));
      sticky_d = 1'b1;
    end
    // User clear beats a simultaneous error; lock tracking carries on regardless.
    if (clr_i) begin
      cnt_d    = '0;
      sticky_d = 1'b0;
    end

    if (err_i) begin
      hold_d = HOLD_LOAD;
    end else if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_SEARCH;
      run_q    <= '0;
      loss_q   <= '0;
      hold_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      lock_q   <= 1'b0;
      led_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      loss_q   <= loss_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      lock_q   <= (state_q == ST_LOCKED);
      led_q    <= (hold_q != '0) || (state_q == ST_SEARCH);
    end
  end

  assign lock_o   = lock_q;
  assign cnt_en_o = cnt_en;
  assign cnt_o    = cnt_q;
  assign sticky_o = sticky_q;
  assign led_o    = led_q;

endmodule

// File: rtl/prbs_err_monitor.sv
// N-lane PRBS checker back-end: per-lane channels, VIO inject edge detector
// and, with PRBS_ERR_TOTAL_EN defined, a saturating all-lane error total.
module prbs_err_monitor
  import prbs_mon_pkg::*;
#(
  parameter int NCH      = 8,
  parameter int CNT_W    = 16,
  parameter int LOCK_CYC = 255,
  parameter int LOSS_CYC = 4,
  parameter int LED_HOLD = 2**20-1
) (
  input logic              txusrclk2,
  input logic              reset,
  prbs_err_monitor_if.slave bus
);
  logic [NCH-1:0] cnt_en;
  logic           inj_prev_q;
  logic           inj_pulse_q, inj_pulse_d;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    prbs_err_chan #(
      .CNT_W    (CNT_W),
      .LOCK_CYC (LOCK_CYC),
      .LOSS_CYC (LOSS_CYC),
      .LED_HOLD (LED_HOLD)
    ) u_chan (
      .clk_i    (txusrclk2),
      .rst_i    (reset),
      .err_i    (bus.PRBS_error[g]),
      .clr_i    (bus.PRBS_counter_reset_user),
      .lock_o   (bus.lock[g]),
      .cnt_en_o (cnt_en[g]),
      .cnt_o    (bus.err_cnt[g*CNT_W +: CNT_W]),
      .sticky_o (bus.err_sticky[g]),
      .led_o    (bus.led_fp[g])
    );
  end

  // Re-arms only once inject has been sampled low.
  assign inj_pulse_d = bus.inject & ~inj_prev_q;

  always_ff @(posedge txusrclk2 or posedge reset) begin
    if (reset) begin
      inj_prev_q  <= 1'b0;
      inj_pulse_q <= 1'b0;
    end else begin
      inj_prev_q  <= bus.inject;
      inj_pulse_q <= inj_pulse_d;
    end
  end

  assign bus.inject_pulse = inj_pulse_q;

`ifdef PRBS_ERR_TOTAL_EN
  localparam int          TOT_W   = CNT_W + $clog2(NCH);
  localparam logic [63:0] TOT_MAX = (64'd1 << TOT_W) - 64'd1;

  logic [TOT_W-1:0] tot_q, tot_d;
  logic [63:0]      hits;

  always_comb begin
    hits = '0;
    for (int i = 0; i < NCH; i++) begin
      hits = hits + 64'(cnt_en[i]);
    end
    tot_d = bus.PRBS_counter_reset_user ? '0
          : TOT_W'(sat_add(64'(tot_q), hits, TOT_MAX));
  end

  always_ff @(posedge txusrclk2 or posedge reset) begin
    if (reset) begin
      tot_q <= '0;
    end else begin
      tot_q <= tot_d;
    end
  end

  assign bus.err_total = tot_q;
`else
  logic cnt_en_unused;
  assign cnt_en_unused = ^cnt_en;
`endif

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Directed + randomized bench for prbs_err_monitor against a cycle-level
// behavioural model of lock tracking, counting, LED stretch and inject.
module tb_prbs_err_monitor;
  localparam int NCH      = 8;
  localparam int CNT_W    = 4;
  localparam int LOCK_CYC = 8;
  localparam int LOSS_CYC = 4;
  localparam int LED_HOLD = 4;
  localparam int CMAX     = (1 << CNT_W) - 1;
  localparam int TOT_W    = CNT_W + $clog2(NCH);
  localparam int TMAX     = (1 << TOT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  prbs_err_monitor_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  prbs_err_monitor #(
    .NCH      (NCH),
    .CNT_W    (CNT_W),
    .LOCK_CYC (LOCK_CYC),
    .LOSS_CYC (LOSS_CYC),
    .LED_HOLD (LED_HOLD)
  ) dut (
    .txusrclk2 (clk),
    .reset     (reset),
    .bus       (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: lane lock status plus streak lengths, counts and error age.
  bit       m_locked [NCH];
  int       m_clean  [NCH];
  int       m_bad    [NCH];
  int       m_cnt    [NCH];
  bit       m_sticky [NCH];
  int       m_age    [NCH];
  int       m_total;
  bit       m_prev_inj;
  logic [NCH-1:0] exp_lock, exp_led;
  logic           exp_pulse;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_locked[i] = 1'b0;
      m_clean[i]  = 0;
      m_bad[i]    = 0;
      m_cnt[i]    = 0;
      m_sticky[i] = 1'b0;
      m_age[i]    = LED_HOLD;
    end
    m_total    = 0;
    m_prev_inj = 1'b0;
    exp_lock   = '0;
    exp_led    = '0;
    exp_pulse  = 1'b0;
  endtask

  task automatic model_edge(input logic [NCH-1:0] e, input logic inj, input logic clr);
    int hits;
    hits = 0;
    for (int i = 0; i < NCH; i++) begin
      exp_lock[i] = m_locked[i];
      exp_led[i]  = (m_age[i] < LED_HOLD) || !m_locked[i];
      if (m_locked[i] && e[i]) begin
        m_cnt[i]    = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        m_sticky[i] = 1'b1;
        hits++;
      end
      if (clr) begin
        m_cnt[i]    = 0;
        m_sticky[i] = 1'b0;
      end
      if (!m_locked[i]) begin
        m_clean[i] = e[i] ? 0 : m_clean[i] + 1;
        if (m_clean[i] == LOCK_CYC) begin
          m_locked[i] = 1'b1;
          m_clean[i]  = 0;
          m_bad[i]    = 0;
        end
      end else begin
        m_bad[i] = e[i] ? m_bad[i] + 1 : 0;
        if (m_bad[i] == LOSS_CYC) begin
          m_locked[i] = 1'b0;
          m_bad[i]    = 0;
          m_clean[i]  = 0;
        end
      end
      m_age[i] = e[i] ? 0 : ((m_age[i] < LED_HOLD) ? m_age[i] + 1 : m_age[i]);
    end
    m_total    = clr ? 0 : ((m_total + hits > TMAX) ? TMAX : m_total + hits);
    exp_pulse  = inj && !m_prev_inj;
    m_prev_inj = inj;
  endtask

  task automatic check_all(input string ph);
    logic [NCH*CNT_W-1:0] ec;
    logic [NCH-1:0]       es;
    for (int i = 0; i < NCH; i++) begin
      ec[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
      es[i]                = m_sticky[i];
    end
    chk({ph, ":lock"},   64'(bus.lock),         64'(exp_lock));
    chk({ph, ":led"},    64'(bus.led_fp),       64'(exp_led));
    chk({ph, ":cnt"},    64'(bus.err_cnt),      64'(ec));
    chk({ph, ":sticky"}, 64'(bus.err_sticky),   64'(es));
    chk({ph, ":pulse"},  64'(bus.inject_pulse), 64'(exp_pulse));
`ifdef PRBS_ERR_TOTAL_EN
    chk({ph, ":total"},  64'(bus.err_total),    64'(m_total));
`endif
  endtask

  task automatic step(input string ph, input logic [NCH-1:0] e, input logic inj, input logic clr);
    bus.PRBS_error              = e;
    bus.inject                  = inj;
    bus.PRBS_counter_reset_user = clr;
    @(posedge clk);
    model_edge(e, inj, clr);
    #1;
    check_all(ph);
  endtask

  function automatic logic [CNT_W-1:0] lane_cnt(input int i);
    return bus.err_cnt[i*CNT_W +: CNT_W];
  endfunction

  initial begin
    int pulses;
    logic [NCH-1:0] e;

    // Reset state
    model_reset();
    reset                       = 1'b1;
    bus.PRBS_error              = '0;
    bus.inject                  = 1'b0;
    bus.PRBS_counter_reset_user = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset_lock", 64'(bus.lock), 64'h0);
    reset = 1'b0;

    // Lock acquisition: threshold reached on edge 8, lock visible after edge 9
    for (int c = 1; c <= 9; c++) begin
      step("acq", '0, 1'b0, 1'b0);
      if (c == 8) chk("acq_lock_pre", 64'(bus.lock), 64'h00);
    end
    chk("acq_lock", 64'(bus.lock), 64'hFF);
    chk("acq_cnt", 64'(bus.err_cnt), 64'h0);
    repeat (LED_HOLD + 1) step("acq_hold", '0, 1'b0, 1'b0);
    chk("acq_led_off", 64'(bus.led_fp), 64'h00);

    // Lock loss on lane 2
    repeat (3) step("loss", 8'h04, 1'b0, 1'b0);
    chk("loss_cnt3", 64'(lane_cnt(2)), 64'd3);
    chk("loss_lock_held", 64'(bus.lock[2]), 64'd1);
    step("loss", 8'h04, 1'b0, 1'b0);
    chk("loss_cnt4", 64'(lane_cnt(2)), 64'd4);
    step("loss", 8'h04, 1'b0, 1'b0);
    chk("loss_unlock", 64'(bus.lock[2]), 64'd0);
    step("loss", 8'h04, 1'b0, 1'b0);
    chk("loss_cnt_frozen", 64'(lane_cnt(2)), 64'd4);
    repeat (LOCK_CYC + 2) step("relock", '0, 1'b0, 1'b0);
    chk("relock_lane2", 64'(bus.lock[2]), 64'd1);

    // Saturation on lane 0
    for (int k = 0; k < 20; k++) begin
      step("sat", 8'h01, 1'b0, 1'b0);
      step("sat", 8'h00, 1'b0, 1'b0);
    end
    chk("sat_cnt", 64'(lane_cnt(0)), 64'd15);
    chk("sat_sticky", 64'(bus.err_sticky[0]), 64'd1);
    step("sat", 8'h01, 1'b0, 1'b0);
    chk("sat_hold", 64'(lane_cnt(0)), 64'd15);

    // Clear priority on lane 5
    step("clr", 8'h20, 1'b0, 1'b0);
    chk("clr_pre", 64'(lane_cnt(5)), 64'd1);
    step("clr", 8'h20, 1'b0, 1'b1);
    chk("clr_cnt", 64'(lane_cnt(5)), 64'd0);
    chk("clr_sticky", 64'(bus.err_sticky[5]), 64'd0);
    chk("clr_lock", 64'(bus.lock[5]), 64'd1);
    step("clr", 8'h00, 1'b0, 1'b0);

    // Inject held high, then 0,1,0,1
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      step("inj_held", '0, 1'b1, 1'b0);
      if (c == 0) chk("inj_first", 64'(bus.inject_pulse), 64'd1);
      pulses += int'(bus.inject_pulse);
    end
    chk("inj_held_count", 64'(pulses), 64'd1);
    pulses = 0;
    step("inj_alt", '0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step("inj_alt", '0, c[0], 1'b0);
      pulses += int'(bus.inject_pulse);
    end
    step("inj_alt", '0, 1'b0, 1'b0);
    chk("inj_alt_count", 64'(pulses), 64'd2);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) e[i] = ($urandom_range(0, 7) == 0);
      step("rand", e, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 31) == 0));
    end

    // Async reset mid-count with a pending inject pulse
    repeat (LOCK_CYC + 4) step("pre_ar", '0, 1'b0, 1'b0);
    step("pre_ar", '0, 1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step("pre_ar", 8'h02, 1'b0, 1'b0);
      step("pre_ar", 8'h00, 1'b0, 1'b0);
    end
    chk("ar_cnt7", 64'(lane_cnt(1)), 64'd7);
    step("pre_ar", '0, 1'b1, 1'b0);
    chk("ar_pulse_pending", 64'(bus.inject_pulse), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_lock",   64'(bus.lock),         64'h0);
    chk("ar_cnt",    64'(bus.err_cnt),      64'h0);
    chk("ar_sticky", 64'(bus.err_sticky),   64'h0);
    chk("ar_led",    64'(bus.led_fp),       64'h0);
    chk("ar_pulse",  64'(bus.inject_pulse), 64'h0);
`ifdef PRBS_ERR_TOTAL_EN
    chk("ar_total",  64'(bus.err_total),    64'h0);
`endif
    model_reset();
    bus.inject = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (LOCK_CYC + 1) step("ar_relock", '0, 1'b0, 1'b0);
    chk("ar_relock_all", 64'(bus.lock), 64'hFF);

`ifdef PRBS_ERR_TOTAL_EN
    step("tot", '0, 1'b0, 1'b1);
    step("tot", 8'h0B, 1'b0, 1'b0);
    chk("tot_plus3", 64'(bus.err_total), 64'd3);
`endif
    step("end", '0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_err_monitor.md
Name: prbs_err_monitor

Overview:
- Parametrised N-channel PRBS checker back-end; replaces direct ILA probing of raw per-link PRBS_error strobes.
- Per channel: lock detection, saturating error count, LED stretch; plus one-shot error inject and user counter clear.
- Sits between the GTX PRBS checkers and the front-panel LEDs and VIO/ILA debug cores, all in the txusrclk2 domain.

Parameters:
- NCH, 8, number of PRBS lanes.
- CNT_W, 16, per-channel error counter width; 2..32.
- LOCK_CYC, 255, consecutive error-free cycles needed to declare lock; >=1.
- LOSS_CYC, 4, consecutive error cycles needed to drop lock; >=1.
- LED_HOLD, 2**20-1, cycles an LED stays lit after the last error; >=1.

Ports:
- txusrclk2  in  1  Sole clock; all logic is synchronous to it.
- reset  in  1  Asynchronous, active-high reset; clears all state.
- PRBS_error  in  NCH  Per-lane error strobe; bit i high = lane i mismatch this cycle.
- inject  in  1  Level request from VIO; its rising edge produces one inject pulse.
- PRBS_counter_reset_user  in  1  Synchronous clear of all error counters and sticky flags while high.
- inject_pulse  out  1  Single-cycle pulse to the TX error-inject input.
- lock  out  NCH  Per-lane lock status.
- err_cnt  out  NCH*CNT_W  Lane i count at [i*CNT_W +: CNT_W].
- err_sticky  out  NCH  Set on any counted error; cleared only by reset or counter clear.
- led_fp  out  NCH  Stretched error indicator, active-high.

Behaviour:
- Reset values: all outputs 0; every lane in SEARCH; clean-run and loss-run counters 0.
- Inputs used directly; PRBS_error is already synchronous to txusrclk2.
- Per-lane FSM, 2 states:
  - SEARCH: clean-run counter increments on each cycle with error=0 and clears on error=1. When the counter reaches LOCK_CYC, the next state is LOCKED and the counter clears. Errors are not counted in SEARCH.
  - LOCKED: each error=1 cycle increments err_cnt (saturating at 2**CNT_W-1, no wrap) and sets err_sticky. The loss-run counter increments on error and clears on a clean cycle. On reaching LOSS_CYC, the next state is SEARCH. The error that triggers the loss is still counted.
- lock = (state==LOCKED), registered; 1-cycle latency from the FSM transition.
- Error to count latency: err_cnt and err_sticky update on the clock edge that samples the error (1 cycle).
- PRBS_counter_reset_user high:
  - err_cnt and err_sticky forced to 0 every cycle it is high.
  - Clear wins over a simultaneous error.
  - FSM state and lock are unaffected.
- led_fp[i]:
  - Any error=1 cycle, in any state, reloads a per-lane hold counter to LED_HOLD; led_fp=1 while the counter is nonzero.
  - A lane in SEARCH also drives led_fp=1, so a never-locked lane lights continuously.
- inject edge detect: inject_pulse = inject & ~inject_d, registered.
  - Held inject gives exactly one pulse.
  - Re-arms only after inject is sampled low.
  - Pulses on back-to-back edges (0,1,0,1) are allowed.
- Asynchronous reset mid-operation: all state returns to reset values immediately; a pending inject_pulse is dropped.

Optional Feature:
- Macro: PRBS_ERR_TOTAL_EN.
- Defined:
  - Adds output err_total [CNT_W+$clog2(NCH)-1:0].
  - Counts, per cycle, the number of LOCKED lanes with error=1 (popcount), saturating.
  - Obeys the same clear and reset rules as err_cnt.
  - Latency: 1 cycle, same as err_cnt.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package prbs_mon_pkg holds:
  - State enum {ST_SEARCH, ST_LOCKED}.
  - Saturating-increment function.
  - Localparam helpers for counter widths ($clog2(LOCK_CYC+1), $clog2(LED_HOLD+1)).
- Sub-module prbs_err_chan: one lane (FSM, counter, sticky, LED stretch), instantiated NCH times with a generate loop.
- The top level holds the inject edge detector and the optional total counter.

Test Plan:
- Lock acquisition: reset, then PRBS_error=0 for LOCK_CYC=8 cycles -> lock=all-ones on cycle 10; err_cnt=0; led_fp=0 after hold expiry (LED_HOLD=4).
- Lock loss: lane 2 locked, error high for 3 cycles with LOSS_CYC=4 -> err_cnt[2]=3, lock held. A 4th cycle -> err_cnt[2]=4, lock[2]=0 next cycle. Further errors leave the count at 4.
- Saturation: CNT_W=4, lane 0 locked, 20 error cycles interleaved with clean cycles so the loss-run counter never reaches LOSS_CYC -> err_cnt[0]=15 and stays 15; err_sticky[0]=1.
- Clear priority: counter clear high on the same cycle as an error on lane 5 -> err_cnt[5]=0, err_sticky[5]=0, lock[5] unchanged.
- Inject: inject held high for 10 cycles -> exactly one inject_pulse, 1 cycle wide, 1 cycle after the edge. Pattern 0,1,0,1 -> two pulses.
- Async reset mid-count: assert reset between clock edges with err_cnt[1]=7 -> all outputs 0 before the next edge; lanes relock after LOCK_CYC clean cycles. With PRBS_ERR_TOTAL_EN, 3 lanes erroring in one cycle -> err_total +3.
